phoneme_sequencer: RTL and testbench
====================================

# phoneme_sequencer

Playback controller for the speech synthesizer. It queues phoneme codes, looks up each phoneme's start and end word addresses in the phoneme table, and fetches 32-bit sample words from flash through a request/acknowledge port. It emits one 8-bit sample per `sample_tick` on `audio_out` and drives the `play` qualifier consumed by the LED level meter.

## Interface
- `FIFO_DEPTH`, 4: phoneme queue depth; power of two, at least 2.
- `ADDR_W`, 23: flash word-address width.
- `GAP_SAMPLES`, 64: silent samples inserted between phonemes (see Configuration).

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ph_valid`  in  1  phoneme code offered.
- `ph_code`  in  6  phoneme code.
- `ph_ready`  out  1  queue can accept a code.
- `sample_tick`  in  1  one-cycle pulse at the audio sample rate.
- `tbl_addr`  out  6  phoneme-table index.
- `tbl_start`  in  ADDR_W  first word address; valid 1 cycle after `tbl_addr` changes.
- `tbl_end`  in  ADDR_W  last word address, inclusive; same timing as `tbl_start`.
- `mem_rd_req`  out  1  flash read request.
- `mem_addr`  out  ADDR_W  read word address.
- `mem_rd_ack`  in  1  read complete; `mem_rd_data` is valid in the same cycle.
- `mem_rd_data`  in  32  read word.
- `audio_out`  out  8  current sample, two's complement.
- `play`  out  1  a phoneme is being played.
- `busy`  out  1  queue non-empty or state is not IDLE.
- `done_pulse`  out  1  one-cycle pulse at the end of each phoneme.
- `underrun`  out  1  sticky flag: a tick arrived with no sample ready.

## Operation
- Queue
  - `ph_ready` = (count < `FIFO_DEPTH`).
  - Push occurs when `ph_valid && ph_ready`.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- States: IDLE, POP, LOOKUP, LATCH, FETCH, EMIT, NEXT, plus GAP when the gap feature is compiled in.
- IDLE: `audio_out`=0, `play`=0. Go to POP when the queue is non-empty.
- POP: drive `tbl_addr` from the queue head, pop the head, go to LOOKUP.
- LOOKUP: wait one cycle for table data, go to LATCH.
- LATCH: `cur`<=`tbl_start`, `end`<=`tbl_end`.
  - If `tbl_start` > `tbl_end`, the entry is empty: go to NEXT with no samples emitted.
  - Otherwise go to FETCH.
- FETCH: `mem_rd_req`=1 and `mem_addr`=`cur`, held stable until `mem_rd_ack`.
  - On ack: latch the word, set byte index to 0, deassert the request the next cycle, go to EMIT.
- EMIT: on each `sample_tick`, `audio_out`<=word byte[idx], with byte 0 = bits 7:0 emitted first, then idx+1.
  - After byte 3 is emitted, if `cur`==`end` go to NEXT.
  - Otherwise `cur`<=`cur`+1 and go to FETCH.
- NEXT: `done_pulse`=1 for one cycle. Go to GAP when the gap feature is compiled in, otherwise to IDLE.
- `play`=1 in LATCH, FETCH and EMIT.
- `audio_out` holds its last value in FETCH, and is forced to 0 in IDLE and GAP.
- Underrun: a `sample_tick` that arrives in FETCH is dropped and sets `underrun`. `underrun` clears only on reset.
- `cur` wraps modulo 2^ADDR_W. Wrap is reached only with the inclusive end; it is not an error.

## Timing
- Reset values: `ph_ready`=1 (queue empty), `mem_rd_req`=0, `mem_addr`=0, `tbl_addr`=0, `audio_out`=0, `play`=0, `busy`=0, `done_pulse`=0, `underrun`=0, state IDLE.
- Reset mid-operation: the queue is flushed and the request drops on the next edge. A late `mem_rd_ack` arriving after reset is ignored.
- Latency from a push into an empty idle queue to `mem_rd_req`=1: 4 cycles (IDLE→POP→LOOKUP→LATCH→FETCH).
- Ack to EMIT: 1 cycle. The first sample appears on the first `sample_tick` seen in EMIT, registered 1 cycle after the tick.
- After the final sample: NEXT follows 1 cycle later, then IDLE; POP follows on the next cycle if the queue is non-empty.
- A `sample_tick` in the same cycle as `mem_rd_ack` counts as an underrun.

## Configuration
- `PHSEQ_GAP_EN` defined:
  - After NEXT the block enters GAP: `audio_out`=0, `play`=0, `busy`=1.
  - GAP counts `GAP_SAMPLES` ticks, then goes to IDLE. Ticks in GAP never set `underrun`.
- `PHSEQ_GAP_EN` undefined: the GAP state and its counter are absent, and NEXT goes directly to IDLE.

## Test plan
- Reset, then push code 5 with table {start=0x10, end=0x11}, ack after 2 cycles, words 0x44332211 and 0x88776655, ticks every 20 cycles -> `audio_out` sequence 11,22,33,44,55,66,77,88, then one `done_pulse`, `play`=0, `underrun`=0.
- Push 5 codes back-to-back into the depth-4 queue while the block is held idle (no ack) -> `ph_ready`=0 after 4 accepted pushes; the 5th is refused.
- Table entry with start=0x20, end=0x1F -> no `mem_rd_req`, `done_pulse` 3 cycles after POP, `audio_out` stays 0.
- Ack delayed 50 cycles with ticks every 10 cycles -> `underrun`=1, `audio_out` holds its last value, and playback completes afterwards.
- Assert `reset` while `mem_rd_req`=1, then send an ack 1 cycle later -> all outputs at reset values, queue empty, ack ignored.
- With `PHSEQ_GAP_EN` and `GAP_SAMPLES`=4, play two one-word phonemes -> exactly 4 ticks at 0 with `play`=0 between the phonemes.

Source files
------------

// File: rtl/phoneme_sequencer.sv
// phoneme_sequencer: queues phoneme codes, looks up each code's flash word range and
// plays the words back one byte per sample tick.
// Optional feature: define PHSEQ_GAP_EN to insert GAP_SAMPLES silent ticks after each phoneme.
module phoneme_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned GAP_SAMPLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ph_valid,
    input  logic [5:0]        ph_code,
    output logic              ph_ready,
    input  logic              sample_tick,
    output logic [5:0]        tbl_addr,
    input  logic [ADDR_W-1:0] tbl_start,
    input  logic [ADDR_W-1:0] tbl_end,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_ack,
    input  logic [31:0]       mem_rd_data,
    output logic [7:0]        audio_out,
    output logic              play,
    output logic              busy,
    output logic              done_pulse,
    output logic              underrun
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StLookup,
        StLatch,
        StFetch,
        StEmit,
        StNext
`ifdef PHSEQ_GAP_EN
        , StGap
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        fifo_q [FIFO_DEPTH];
    logic [5:0]        fifo_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [5:0]        tbl_addr_q, tbl_addr_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        audio_q, audio_d;
    logic              play_q, play_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic              push, pop;

`ifdef PHSEQ_GAP_EN
    localparam int unsigned GapW = $clog2(GAP_SAMPLES) + 1;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`else
    // GAP_SAMPLES only matters when the gap state is built.
    logic unused_gap_cfg;
    assign unused_gap_cfg = (GAP_SAMPLES != 0);
`endif

    // A full queue refuses pushes even when the head is popped in the same cycle.
    assign ph_ready = (count_q < CntW'(FIFO_DEPTH));
    assign push     = ph_valid && ph_ready;
    assign pop      = (state_q == StPop);

    // Queue bookkeeping.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = ph_code;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Playback state machine and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tbl_addr_d = tbl_addr_q;
        audio_d    = audio_q;
        // Ticks in FETCH are dropped, including one coinciding with the ack.
        underrun_d = underrun_q | (sample_tick && (state_q == StFetch));
`ifdef PHSEQ_GAP_EN
        gap_cnt_d  = gap_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) state_d = StPop;
            end
            StPop: begin
                tbl_addr_d = fifo_q[rd_ptr_q];
                state_d    = StLookup;
            end
            StLookup: begin
                state_d = StLatch;
            end
            StLatch: begin
                cur_d   = tbl_start;
                last_d  = tbl_end;
                // start beyond end marks an empty entry
                state_d = (tbl_start > tbl_end) ? StNext : StFetch;
            end
            StFetch: begin
                if (mem_rd_ack) begin
                    word_d  = mem_rd_data;
                    idx_d   = '0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (sample_tick) begin
                    audio_d = word_q[{idx_q, 3'b000} +: 8];
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (cur_q == last_q) begin
                            state_d = StNext;
                        end else begin
                            cur_d   = cur_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                    end
                end
            end
            StNext: begin
`ifdef PHSEQ_GAP_EN
                gap_cnt_d = '0;
                state_d   = StGap;
`else
                state_d   = StIdle;
`endif
            end
`ifdef PHSEQ_GAP_EN
            StGap: begin
                if (sample_tick) begin
                    if (gap_cnt_q == GapW'(GAP_SAMPLES - 1)) state_d = StIdle;
                    else gap_cnt_d = gap_cnt_q + GapW'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they follow the state being entered.
        if (state_d == StIdle) audio_d = '0;
`ifdef PHSEQ_GAP_EN
        if (state_d == StGap) audio_d = '0;
`endif
        play_d     = (state_d == StLatch) || (state_d == StFetch) || (state_d == StEmit);
        req_d      = (state_d == StFetch);
        mem_addr_d = (state_d == StFetch) ? cur_d : mem_addr_q;
        done_d     = (state_d == StNext);
        busy_d     = (count_d != '0) || (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cur_q      <= '0;
            last_q     <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            tbl_addr_q <= '0;
            req_q      <= 1'b0;
            mem_addr_q <= '0;
            audio_q    <= '0;
            play_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef PHSEQ_GAP_EN
            gap_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            tbl_addr_q <= tbl_addr_d;
            req_q      <= req_d;
            mem_addr_q <= mem_addr_d;
            audio_q    <= audio_d;
            play_q     <= play_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
`ifdef PHSEQ_GAP_EN
            gap_cnt_q  <= gap_cnt_d;
`endif
        end
    end

    assign tbl_addr   = tbl_addr_q;
    assign mem_rd_req = req_q;
    assign mem_addr   = mem_addr_q;
    assign audio_out  = audio_q;
    assign play       = play_q;
    assign busy       = busy_q;
    assign done_pulse = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_phoneme_sequencer.sv
// Directed bench for phoneme_sequencer with a sample scoreboard, a one-cycle-latency
// phoneme table model and a flash responder with programmable ack delay.
module tb_phoneme_sequencer;

    localparam int unsigned AW = 23;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ph_valid = 1'b0;
    logic [5:0]    ph_code = '0;
    logic          ph_ready;
    logic          sample_tick = 1'b0;
    logic [5:0]    tbl_addr;
    logic [AW-1:0] tbl_start = '0;
    logic [AW-1:0] tbl_end = '0;
    logic          mem_rd_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_ack = 1'b0;
    logic [31:0]   mem_rd_data = '0;
    logic [7:0]    audio_out;
    logic          play;
    logic          busy;
    logic          done_pulse;
    logic          underrun;

    phoneme_sequencer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (AW),
        .GAP_SAMPLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ph_valid   (ph_valid),
        .ph_code    (ph_code),
        .ph_ready   (ph_ready),
        .sample_tick(sample_tick),
        .tbl_addr   (tbl_addr),
        .tbl_start  (tbl_start),
        .tbl_end    (tbl_end),
        .mem_rd_req (mem_rd_req),
        .mem_addr   (mem_addr),
        .mem_rd_ack (mem_rd_ack),
        .mem_rd_data(mem_rd_data),
        .audio_out  (audio_out),
        .play       (play),
        .busy       (busy),
        .done_pulse (done_pulse),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [7:0]    exp_q [$];
    logic [7:0]    last_audio = 8'h00;
    int            done_cnt = 0;
    bit            req_seen = 1'b0;
    int            tick_period = 0;
    int            tick_cnt = 0;
    int            ack_delay = 2;
    bit            ack_enable = 1'b1;
    int            wait_cnt = 0;
    bit            force_ack = 1'b0;
    logic [5:0]    tbl_addr_prev = '0;
    logic [AW-1:0] tbl_s_m [64];
    logic [AW-1:0] tbl_e_m [64];
    logic [31:0]   mem_m [logic [AW-1:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1ns after the edge, then drive the models' inputs.
    task automatic step();
        @(posedge clk);
        #1;
        // every new non-zero audio value is one emitted sample
        if (audio_out !== last_audio) begin
            if (audio_out !== 8'h00) begin
                if (exp_q.size() == 0) check("audio_unexpected", {24'h0, audio_out}, 32'h0);
                else check("audio_sample", {24'h0, audio_out}, {24'h0, exp_q.pop_front()});
            end
            last_audio = audio_out;
        end
        if (done_pulse === 1'b1) done_cnt++;
        if (mem_rd_req === 1'b1) req_seen = 1'b1;
        // table data follows the address with one cycle of latency
        tbl_start     = tbl_s_m[tbl_addr_prev];
        tbl_end       = tbl_e_m[tbl_addr_prev];
        tbl_addr_prev = tbl_addr;
        // flash responder
        mem_rd_ack = 1'b0;
        if (force_ack) begin
            mem_rd_ack  = 1'b1;
            mem_rd_data = 32'hDEADBEEF;
            force_ack   = 1'b0;
        end else if (ack_enable && mem_rd_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
                mem_rd_ack  = 1'b1;
                mem_rd_data = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 32'h0;
                wait_cnt    = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        // sample-rate tick
        sample_tick = 1'b0;
        if (tick_period > 0) begin
            tick_cnt++;
            if (tick_cnt >= tick_period) begin
                sample_tick = 1'b1;
                tick_cnt    = 0;
            end
        end
    endtask

    task automatic push(input logic [5:0] code);
        ph_valid = 1'b1;
        ph_code  = code;
        step();
        ph_valid = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset       = 1'b0;
        exp_q.delete();
        done_cnt    = 0;
        req_seen    = 1'b0;
        tick_period = 0;
        ack_enable  = 1'b1;
        ack_delay   = 2;
    endtask

    task automatic wait_done(input int target, input int limit, input string tag);
        int n = 0;
        while (done_cnt < target && n < limit) begin
            step();
            n++;
        end
        check(tag, done_cnt, target);
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        check(tag, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int n;
        int gap_ticks;
        logic rdy [5];
        logic [5:0] codes [5];

        for (int i = 0; i < 64; i++) begin
            tbl_s_m[i] = '0;
            tbl_e_m[i] = '0;
        end
        tbl_s_m[5] = 23'h10; tbl_e_m[5] = 23'h11;
        tbl_s_m[7] = 23'h20; tbl_e_m[7] = 23'h1F;
        tbl_s_m[1] = 23'h30; tbl_e_m[1] = 23'h30;
        tbl_s_m[2] = 23'h31; tbl_e_m[2] = 23'h31;
        tbl_s_m[3] = 23'h32; tbl_e_m[3] = 23'h32;
        tbl_s_m[4] = 23'h33; tbl_e_m[4] = 23'h33;
        tbl_s_m[6] = 23'h34; tbl_e_m[6] = 23'h34;
        mem_m[23'h10] = 32'h44332211;
        mem_m[23'h11] = 32'h88776655;
        mem_m[23'h30] = 32'h9C9B9A99;
        mem_m[23'h31] = 32'hA4A3A2A1;
        mem_m[23'h32] = 32'hACABAAA9;
        mem_m[23'h33] = 32'hB4B3B2B1;
        mem_m[23'h34] = 32'hEEEEEEEE;

        // Reset values
        do_reset();
        step();
        check("rst_ph_ready", {31'h0, ph_ready}, 32'h1);
        check("rst_req", {31'h0, mem_rd_req}, 32'h0);
        check("rst_mem_addr", {9'h0, mem_addr}, 32'h0);
        check("rst_tbl_addr", {26'h0, tbl_addr}, 32'h0);
        check("rst_audio", {24'h0, audio_out}, 32'h0);
        check("rst_play", {31'h0, play}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done_pulse}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);

        // Two-word phoneme, ack after 2 cycles, ticks every 20
        expect_word(32'h44332211);
        expect_word(32'h88776655);
        tick_period = 20;
        tick_cnt    = 0;
        push(6'd5);
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("t1_req_latency", n, 4);
        check("t1_req_addr", {9'h0, mem_addr}, 32'h10);
        check("t1_tbl_addr", {26'h0, tbl_addr}, 32'h5);
        check("t1_play_fetch", {31'h0, play}, 32'h1);
        check("t1_busy_fetch", {31'h0, busy}, 32'h1);
        wait_done(1, 1000, "t1_done");
        check("t1_play_at_done", {31'h0, play}, 32'h0);
        check("t1_samples_left", exp_q.size(), 0);
        wait_idle(300, "t1_idle");
        check("t1_audio_idle", {24'h0, audio_out}, 32'h0);
        check("t1_underrun", {31'h0, underrun}, 32'h0);
        repeat (5) step();
        check("t1_one_done", done_cnt, 1);

        // Queue fills to depth while the block is stalled in FETCH
        do_reset();
        ack_enable = 1'b0;
        push(6'd5);
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("q_stall_req", {31'h0, mem_rd_req}, 32'h1);
        codes[0] = 6'd1; codes[1] = 6'd2; codes[2] = 6'd3; codes[3] = 6'd4; codes[4] = 6'd6;
        ph_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ph_code = codes[i];
            rdy[i]  = ph_ready;
            step();
        end
        ph_valid = 1'b0;
        check("q_ready_4th", {31'h0, rdy[3]}, 32'h1);
        check("q_ready_5th", {31'h0, rdy[4]}, 32'h0);
        check("q_full", {31'h0, ph_ready}, 32'h0);
        expect_word(32'h44332211);
        expect_word(32'h88776655);
        expect_word(32'h9C9B9A99);
        expect_word(32'hA4A3A2A1);
        expect_word(32'hACABAAA9);
        expect_word(32'hB4B3B2B1);
        ack_enable  = 1'b1;
        tick_period = 20;
        tick_cnt    = 0;
        wait_done(5, 6000, "q_done5");
        wait_idle(600, "q_idle");
        check("q_done_total", done_cnt, 5);
        check("q_samples_left", exp_q.size(), 0);
        check("q_underrun", {31'h0, underrun}, 32'h0);

        // Empty table entry
        do_reset();
        push(6'd7);
        n = 0;
        while (done_pulse !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("empty_done_latency", n, 4);
        check("empty_tbl_addr", {26'h0, tbl_addr}, 32'h7);
        repeat (3) step();
        check("empty_no_req", {31'h0, req_seen}, 32'h0);
        check("empty_audio", {24'h0, audio_out}, 32'h0);
        check("empty_play", {31'h0, play}, 32'h0);
        check("empty_one_done", done_cnt, 1);
`ifdef PHSEQ_GAP_EN
        check("empty_busy_gap", {31'h0, busy}, 32'h1);
`else
        check("empty_busy", {31'h0, busy}, 32'h0);
`endif

        // Underrun: ack delayed 50 cycles, ticks every 10
        do_reset();
        ack_delay   = 50;
        tick_period = 10;
        tick_cnt    = 0;
        expect_word(32'h44332211);
        expect_word(32'h88776655);
        push(6'd5);
        n = 0;
        while (exp_q.size() > 4 && n < 400) begin
            step();
            n++;
        end
        check("ur_first_word", exp_q.size(), 4);
        check("ur_flag", {31'h0, underrun}, 32'h1);
        repeat (30) step();
        check("ur_stall_req", {31'h0, mem_rd_req}, 32'h1);
        check("ur_hold_audio", {24'h0, audio_out}, 32'h44);
        check("ur_play", {31'h0, play}, 32'h1);
        wait_done(1, 1000, "ur_done");
        check("ur_samples_left", exp_q.size(), 0);
        check("ur_sticky", {31'h0, underrun}, 32'h1);

        // Reset while a read is pending, late ack one cycle after
        do_reset();
        ack_enable = 1'b0;
        push(6'd5);
        push(6'd1);
        n = 0;
        while (mem_rd_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("mr_req_before", {31'h0, mem_rd_req}, 32'h1);
        reset     = 1'b1;
        force_ack = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("mr_req", {31'h0, mem_rd_req}, 32'h0);
        check("mr_mem_addr", {9'h0, mem_addr}, 32'h0);
        check("mr_tbl_addr", {26'h0, tbl_addr}, 32'h0);
        check("mr_audio", {24'h0, audio_out}, 32'h0);
        check("mr_play", {31'h0, play}, 32'h0);
        check("mr_busy", {31'h0, busy}, 32'h0);
        check("mr_done", {31'h0, done_pulse}, 32'h0);
        check("mr_underrun", {31'h0, underrun}, 32'h0);
        check("mr_ph_ready", {31'h0, ph_ready}, 32'h1);
        req_seen = 1'b0;
        repeat (10) step();
        check("mr_no_req", {31'h0, req_seen}, 32'h0);
        check("mr_still_idle", {31'h0, busy}, 32'h0);

`ifdef PHSEQ_GAP_EN
        // Silent gap between two one-word phonemes
        do_reset();
        expect_word(32'h9C9B9A99);
        expect_word(32'hA4A3A2A1);
        tick_period = 20;
        tick_cnt    = 0;
        push(6'd1);
        push(6'd2);
        wait_done(1, 1000, "gap_first_done");
        gap_ticks = 0;
        n = 0;
        while (n < 500) begin
            step();
            n++;
            if (play === 1'b1) break;
            if (sample_tick === 1'b1) begin
                gap_ticks++;
                check("gap_audio_zero", {24'h0, audio_out}, 32'h0);
                check("gap_busy", {31'h0, busy}, 32'h1);
            end
        end
        check("gap_tick_count", gap_ticks, 4);
        wait_done(2, 1000, "gap_second_done");
        check("gap_samples_left", exp_q.size(), 0);
        check("gap_underrun", {31'h0, underrun}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
